// File: rtl/pixel_op_pipe.sv
// pixel_op_pipe: streaming per-pixel point operator (brighten, darken,
// threshold, invert, passthrough) on packed NCH x CW pixels. It is a
// two-stage valid/ready pipeline. Mode, value and threshold are captured
// on the first beat of each frame, so every pixel in a frame uses the same
// operation.
// Optional feature macro: PIXEL_OP_GRAY_EN. When it is defined, mode 3'b100
// performs a grayscale conversion (this needs NCH == 3). When it is not
// defined, mode 3'b100 is passthrough.
module pixel_op_pipe #(
    parameter int CW  = 4,
    parameter int NCH = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        mode,
    input  logic [CW-1:0]     value,
    input  logic [CW-1:0]     threshold,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NCH*CW-1:0] in_pixel,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NCH*CW-1:0] out_pixel,
    output logic              out_last,
    output logic              frame_active
);

    localparam int PW = NCH * CW;

    localparam logic [2:0] MODE_BRIGHT = 3'b000;
    localparam logic [2:0] MODE_DARK   = 3'b001;
    localparam logic [2:0] MODE_THRESH = 3'b010;
    localparam logic [2:0] MODE_INVERT = 3'b011;
`ifdef PIXEL_OP_GRAY_EN
    localparam logic [2:0] MODE_GRAY   = 3'b100;
`endif

    // Channel add that clamps to full scale instead of wrapping.
    function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] c,
                                              input logic [CW-1:0] v);
        logic [CW:0] s;
        s = {1'b0, c} + {1'b0, v};
        return s[CW] ? {CW{1'b1}} : s[CW-1:0];
    endfunction

    // Channel subtract that clamps to zero instead of wrapping.
    function automatic logic [CW-1:0] sat_sub(input logic [CW-1:0] c,
                                              input logic [CW-1:0] v);
        logic signed [CW:0] d;
        d = $signed({1'b0, c}) - $signed({1'b0, v});
        return (d < 0) ? '0 : d[CW-1:0];
    endfunction

    // Point operation on one channel. Codes that are not listed pass the
    // channel through unchanged.
    function automatic logic [CW-1:0] op_ch(input logic [CW-1:0] c,
                                            input logic [2:0]    m,
                                            input logic [CW-1:0] v,
                                            input logic [CW-1:0] t);
        logic [CW-1:0] r;
        case (m)
            MODE_BRIGHT: r = sat_add(c, v);
            MODE_DARK:   r = sat_sub(c, v);
            MODE_THRESH: r = (c >= t) ? {CW{1'b1}} : '0;
            MODE_INVERT: r = ~c;
            default:     r = c;
        endcase
        return r;
    endfunction

    logic [2:0]    mode_s;
    logic [CW-1:0] value_s;
    logic [CW-1:0] thr_s;

    logic          vld_p1;
    logic [PW-1:0] pix_p1;
    logic          last_p1;
    logic          vld_p2;
    logic [PW-1:0] pix_p2;
    logic          last_p2;

    logic          s1_load;
    logic          s2_load;
    logic          accept;

    logic [2:0]    mode_e;
    logic [CW-1:0] value_e;
    logic [CW-1:0] thr_e;
    logic [PW-1:0] result;

    assign s2_load  = !vld_p2 || out_ready;
    assign s1_load  = !vld_p1 || s2_load;
    assign in_ready = s1_load;
    assign accept   = in_valid && s1_load;

    // The first beat of a frame uses the live settings, which are captured
    // on that same beat. Every later beat uses the captured copy.
    assign mode_e  = frame_active ? mode_s  : mode;
    assign value_e = frame_active ? value_s : value;
    assign thr_e   = frame_active ? thr_s   : threshold;

`ifdef PIXEL_OP_GRAY_EN
    logic [PW-1:0] gray_pix;
    generate
        if (NCH == 3) begin : g_gray
            logic [CW+1:0] ysum;
            assign ysum = {2'b00, in_pixel[CW-1:0]}
                        + {1'b0, in_pixel[2*CW-1:CW], 1'b0}
                        + {2'b00, in_pixel[3*CW-1:2*CW]};
            assign gray_pix = {NCH{ysum[CW+1:2]}};
        end else begin : g_nogray
            assign gray_pix = in_pixel;
        end
    endgenerate
`endif

    // Apply the selected operation to every channel of the incoming pixel.
    always_comb begin
        result = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            result[ch*CW +: CW] = op_ch(in_pixel[ch*CW +: CW], mode_e, value_e, thr_e);
        end
`ifdef PIXEL_OP_GRAY_EN
        if (mode_e == MODE_GRAY) begin
            result = gray_pix;
        end
`endif
    end

    // Control state: the stage valid bits, the frame-in-progress flag and
    // the settings captured at the start of each frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1       <= 1'b0;
            vld_p2       <= 1'b0;
            frame_active <= 1'b0;
            mode_s       <= '0;
            value_s      <= '0;
            thr_s        <= '0;
        end else begin
            if (s1_load) begin
                vld_p1 <= in_valid;
            end
            if (s2_load) begin
                vld_p2 <= vld_p1;
            end
            if (accept) begin
                if (!frame_active) begin
                    mode_s  <= mode;
                    value_s <= value;
                    thr_s   <= threshold;
                end
                frame_active <= !in_last;
            end
        end
    end

    // ---- stage 1: register the computed pixel and its last flag ----
    always_ff @(posedge clk) begin
        if (accept) begin
            pix_p1  <= result;
            last_p1 <= in_last;
        end
    end

    // ---- stage 2: output register; it holds while downstream stalls ----
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_p2  <= '0;
            last_p2 <= 1'b0;
        end else if (s2_load && vld_p1) begin
            pix_p2  <= pix_p1;
            last_p2 <= last_p1;
        end
    end

    assign out_valid = vld_p2;
    assign out_pixel = pix_p2;
    assign out_last  = last_p2;

endmodule

// File: tb/tb_pixel_op_pipe.sv
// Testbench for pixel_op_pipe. It uses a scoreboard: the stimulus pushes
// the hand-computed expected {last, pixel} when each beat is accepted, and
// an independent monitor pops and compares that entry on every output
// transfer.
module tb_pixel_op_pipe;

    localparam int CW  = 4;
    localparam int NCH = 3;
    localparam int PW  = CW * NCH;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [2:0]    mode = 3'b000;
    logic [CW-1:0] value = '0;
    logic [CW-1:0] threshold = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [PW-1:0] in_pixel = '0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [PW-1:0] out_pixel;
    logic          out_last;
    logic          frame_active;

    int checks = 0;
    int errors = 0;
    logic bp_en = 1'b0;
    logic [PW:0] sb[$];

    pixel_op_pipe #(.CW(CW), .NCH(NCH)) dut (
        .clk(clk), .rst(rst), .mode(mode), .value(value), .threshold(threshold),
        .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
        .out_last(out_last), .frame_active(frame_active)
    );

    always #5 clk = ~clk;

    // Backpressure: out_ready changes just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (bp_en) out_ready = ~out_ready;
        else       out_ready = 1'b1;
    end

    // Monitor: compare each transfer with the scoreboard, flag any output
    // that nothing expects, and check that data holds while stalled.
    logic        stall_prev = 1'b0;
    logic [PW:0] held = '0;
    always @(negedge clk) begin
        if (!rst) begin
            if (stall_prev) begin
                checks++;
                if (!out_valid || {out_last, out_pixel} != held) begin
                    errors++;
                    $display("FAIL hold: got valid=%0b %h required valid=1 %h",
                             out_valid, {out_last, out_pixel}, held);
                end
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_out: got %h required no output", {out_last, out_pixel});
                end else if (out_ready) begin
                    logic [PW:0] e;
                    e = sb.pop_front();
                    checks++;
                    if ({out_last, out_pixel} != e) begin
                        errors++;
                        $display("FAIL out: got last=%0b pix=%h required last=%0b pix=%h",
                                 out_last, out_pixel, e[PW], e[PW-1:0]);
                    end
                end
            end
            stall_prev = out_valid && !out_ready;
            held = {out_last, out_pixel};
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Present one beat and hold it until it is accepted, then push its
    // expected response. The call returns just after the accepting edge.
    task automatic send(input logic [PW-1:0] px, input logic last, input logic [PW-1:0] exp);
        logic acc;
        int n;
        acc = 1'b0;
        n = 0;
        @(negedge clk);
        in_pixel = px; in_last = last; in_valid = 1'b1;
        while (!acc && n < 50) begin
            #2;
            acc = in_ready;
            @(posedge clk);
            n++;
            if (!acc) @(negedge clk);
        end
        #1 in_valid = 1'b0;
        if (acc) sb.push_back({last, exp});
        else begin
            checks++; errors++;
            $display("FAIL send_timeout: got no accept required accept of %h", px);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size(), 0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pixel", out_pixel, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_frame_active", frame_active, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);

        // Brighten with saturation; out_valid 2 cycles after accept, for 1 cycle
        mode = 3'b000; value = 4'd5;
        send(12'hC3F, 1'b1, 12'hF8F);
        @(negedge clk);
        chk("lat_cycle1_valid", out_valid, 0);
        chk("single_beat_frame_active", frame_active, 0);
        @(negedge clk);
        chk("lat_cycle2_valid", out_valid, 1);
        chk("lat_cycle2_pixel", out_pixel, 12'hF8F);
        @(negedge clk);
        chk("lat_cycle3_valid", out_valid, 0);

        // Darken, threshold (including equality), passthrough code
        mode = 3'b001; value = 4'd4;
        send(12'h2A5, 1'b1, 12'h061);
        mode = 3'b010; threshold = 4'd8;
        send(12'h79F, 1'b1, 12'h0FF);
        threshold = 4'd5;
        send(12'h456, 1'b1, 12'h0FF);
        mode = 3'b111;
        send(12'h5A3, 1'b1, 12'h5A3);
        drain();

        // Frame latching: settings changed after beat 1 are ignored until the frame ends
        mode = 3'b011;
        send(12'h123, 1'b0, 12'hEDC);
        @(negedge clk);
        chk("frame_active_set", frame_active, 1);
        mode = 3'b000; value = 4'd1;
        send(12'h123, 1'b0, 12'hEDC);
        send(12'h123, 1'b1, 12'hEDC);
        @(negedge clk);
        chk("frame_active_clear", frame_active, 0);
        send(12'h123, 1'b1, 12'h234);
        drain();

        // Backpressure: 8 passthrough beats with out_ready toggling
        mode = 3'b111;
        bp_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [PW-1:0] p;
            p = 12'h111 * (i + 1) ^ 12'h0A5;
            send(p, (i == 7), p);
        end
        drain();
        bp_en = 1'b0;
        @(negedge clk);

        // Reset mid-frame with beats in flight
        mode = 3'b011;
        send(12'h111, 1'b0, 12'hEEE);
        send(12'h222, 1'b0, 12'hDDD);
        @(negedge clk);
        rst = 1'b1; in_pixel = 12'h333; in_last = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_frame_active", frame_active, 0);
        sb.delete();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", in_ready, 1);
        repeat (4) @(negedge clk);
        mode = 3'b001; value = 4'd4;
        send(12'h2A5, 1'b1, 12'h061);
        drain();

        // Grayscale mode code
        mode = 3'b100;
`ifdef PIXEL_OP_GRAY_EN
        send(12'h48C, 1'b1, 12'h888);
`else
        send(12'h48C, 1'b1, 12'h48C);
`endif
        drain();
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_op_pipe.md
# pixel_op_pipe

Parametrised, streaming per-pixel operator for the camera-to-display pixel path: applies one of several point operations (brighten, darken, threshold, invert, optional grayscale) to packed multi-channel pixels. Replaces the single-mode, enable-gated pixel operator with a two-stage valid/ready pipeline. Operation settings are latched at frame boundaries, so a frame never mixes modes.

## Interface
- CW, 4, bits per colour channel
- NCH, 3, channels per pixel; channel 0 is the LSBs, channel NCH-1 the MSBs
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- mode  in  3  requested operation, sampled at frame start
- value  in  CW  brighten/darken amount, sampled at frame start
- threshold  in  CW  threshold level, sampled at frame start
- in_valid  in  1  in_pixel/in_last valid
- in_ready  out  1  block accepts input this cycle
- in_pixel  in  NCH*CW  input pixel
- in_last  in  1  final pixel of frame
- out_valid  out  1  out_pixel/out_last valid
- out_ready  in  1  downstream accepts output
- out_pixel  out  NCH*CW  processed pixel
- out_last  out  1  in_last, delayed with its pixel
- frame_active  out  1  settings locked (a frame is in progress)

## Operation
- Input accepted when in_valid && in_ready; output transferred when out_valid && out_ready.
- Settings shadow: mode/value/threshold are copied into shadow registers on the first accepted beat after reset or after an accepted in_last, and are used for every pixel of that frame. frame_active is set by that beat and cleared by an accepted in_last. A single-beat frame (in_last on first beat) latches settings and leaves frame_active at 0.
- Per channel c, with shadow values v and t, using CW+1-bit intermediates:
- 000 brighten: min(c+v, 2^CW-1)
- 001 darken: max(c-v, 0)
- 010 threshold: (c >= t) ? 2^CW-1 : 0
- 011 invert: (2^CW-1) - c
- 100 grayscale (macro only): y = (ch0 + 2*ch1 + ch2) >> 2, truncated; y replicated to all channels; requires NCH==3
- all other codes: passthrough
- Stage 1 registers the computed pixel and last flag; stage 2 is the output register.

## Timing
- Latency: 2 cycles from accepted input to out_valid with no backpressure; throughput 1 pixel/cycle.
- s2 loads when !out_valid || out_ready; s1 loads when !s1_valid || s2 loads; in_ready = !s1_valid || s2 loads (combinational from out_ready).
- out_pixel/out_last hold stable while out_valid && !out_ready.
- Reset: out_valid=0, out_pixel=0, out_last=0, frame_active=0, shadow settings = 0 (brighten by 0); in_ready=1 in the cycle after reset deasserts. Reset mid-frame discards both stages; the next accepted beat starts a new frame.
- Changing mode/value/threshold mid-frame has no effect until after the frame's in_last is accepted.
- Simultaneous in_last accept and new first beat are impossible (one beat per cycle); the beat after in_last always relatches.

## Configuration
- PIXEL_OP_GRAY_EN defined: mode 100 performs grayscale as above.
- Not defined: mode 100 is passthrough; grayscale adders are not synthesised.

## Test plan
- Brighten saturation: CW=4, mode 000, value 5, pixel 0xC3F -> 0xF8F after 2 cycles, out_valid 1 cycle.
- Darken/threshold: mode 001 value 4 pixel 0x2A5 -> 0x061; mode 010 threshold 8 pixel 0x79F -> 0x0FF.
- Frame latching: frame 1 mode 011, mode switched to 000 after beat 1 of 3; all 3 outputs inverted (0x123 -> 0xEDC); frame 2 uses brighten.
- Backpressure: stream 8 pixels with out_ready toggling 1/0; all 8 outputs in order, none dropped or duplicated, held stable while stalled, out_last on beat 8 only.
- Reset mid-frame: rst during beat 3 with 2 in flight -> out_valid 0 next cycle, frame_active 0, no stale outputs afterwards.
- Grayscale: with PIXEL_OP_GRAY_EN, mode 100 pixel 0x48C -> y=(12+16+4)>>2=8 -> 0x888; without macro -> 0x48C.
